// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared types and constants for the sysid boot-time check sequencer.
//   state_t       : sequencer states
//   FC_*          : verdict codes reported on fail_code
//   SMP_CNT_W     : sample counter width (holds 0..14, SAMPLES range 1..15)
//   RETRY_CNT_W   : retry counter width (holds 0..15, MAX_RETRIES range 0..15)
// -----------------------------------------------------------------------------
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_ID,
        ST_SMP_ID,
        ST_SET_TS,
        ST_SMP_TS,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_ID       = 2'd1;
    localparam logic [1:0] FC_TS       = 2'd2;
    localparam logic [1:0] FC_UNSTABLE = 2'd3;

    localparam int SMP_CNT_W   = 4;
    localparam int RETRY_CNT_W = 4;

endpackage

// File: rtl/sysid_word_sampler.sv
// -----------------------------------------------------------------------------
// sysid_word_sampler
// Samples one 32-bit word on SAMPLES consecutive enabled cycles. The first
// sample is captured; any later sample that differs sets a sticky unstable
// flag. Shared by the ID and TS phases: the counter returns to zero after the
// last sample of a phase, so the next phase starts cleanly, while the unstable
// flag persists until i_clear.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   i_clear        : clears counter, capture and unstable flag
//   i_enable       : take one sample of i_data this cycle
//   i_data         : word being sampled
//   o_last         : this enabled cycle is the final sample of the phase
//   o_word         : captured word as it will be after this cycle's edge
//   o_unstable     : sticky unstable flag
// -----------------------------------------------------------------------------
module sysid_word_sampler
    import sysid_check_pkg::*;
#(
    parameter int SAMPLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_data,
    output logic        o_last,
    output logic [31:0] o_word,
    output logic        o_unstable
);

    logic [SMP_CNT_W-1:0] r_count;
    logic [31:0]          r_capture;
    logic                 r_unstable;
    logic                 w_first;

    assign w_first    = (r_count == '0);
    assign o_last     = i_enable && (r_count == SMP_CNT_W'(SAMPLES - 1));
    // On the first sample the capture register is only loaded at the edge,
    // so forward the live data; this matters when SAMPLES is 1.
    assign o_word     = w_first ? i_data : r_capture;
    assign o_unstable = r_unstable;

    // NOTE: all state here uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_capture  <= '0;
            r_unstable <= 1'b0;
        end else if (i_clear) begin
            r_count    <= '0;
            r_capture  <= '0;
            r_unstable <= 1'b0;
        end else if (i_enable) begin
            if (w_first) begin
                r_capture <= i_data;
            end else if (i_data != r_capture) begin
                r_unstable <= 1'b1;
            end
            r_count <= o_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Boot-time sequencer that reads the sysid ID word (address 0) and timestamp
// word (address 1), samples each SAMPLES times for stability, compares them
// against EXPECTED_ID / EXPECTED_TS, retries up to MAX_RETRIES times and
// latches a pass/fail verdict with the captured words.
// Ports:
//   clock, reset_n  : clock, async active-low reset
//   start           : single-cycle launch pulse (accepted in IDLE or DONE)
//   sysid_address   : address driven to the sysid slave
//   sysid_readdata  : sysid slave read data
//   busy            : check in progress
//   done            : verdict valid, held until the next accepted start
//   pass            : 1 when both words matched and were stable
//   fail_code       : FC_NONE / FC_ID / FC_TS / FC_UNSTABLE
//   captured_id/ts  : first sample of each word from the latest pass
//   retry_count     : retries consumed by the current or last check
// -----------------------------------------------------------------------------
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1365185748,
    parameter int          SAMPLES     = 4,
    parameter int          MAX_RETRIES = 3,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [3:0]  retry_count
);

    state_t                 r_state;
    logic                   r_auto_pending;
    logic                   r_address;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [1:0]             r_fail_code;
    logic [31:0]            r_captured_id;
    logic [31:0]            r_captured_ts;
    logic [RETRY_CNT_W-1:0] r_retry_count;

    logic                   w_smp_clear;
    logic                   w_smp_en;
    logic                   w_smp_last;
    logic [31:0]            w_smp_word;
    logic                   w_unstable;
    logic [1:0]             w_fail;

    // SET_ID is entered only at launch or retry, which is exactly when the
    // sticky unstable flag must start fresh.
    assign w_smp_clear = (r_state == ST_SET_ID);
    assign w_smp_en    = (r_state == ST_SMP_ID) || (r_state == ST_SMP_TS);

    sysid_word_sampler #(
        .SAMPLES (SAMPLES)
    ) u_sampler (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (w_smp_clear),
        .i_enable   (w_smp_en),
        .i_data     (sysid_readdata),
        .o_last     (w_smp_last),
        .o_word     (w_smp_word),
        .o_unstable (w_unstable)
    );

    // Highest-priority failure: unstable, then ID, then TS.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_fail = FC_NONE;
        if (w_unstable) begin
            w_fail = FC_UNSTABLE;
        end else if (r_captured_id != EXPECTED_ID) begin
            w_fail = FC_ID;
        end else if (r_captured_ts != EXPECTED_TS) begin
            w_fail = FC_TS;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_auto_pending <= AUTO_START;
            r_address      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail_code    <= FC_NONE;
            r_captured_id  <= '0;
            r_captured_ts  <= '0;
            r_retry_count  <= '0;
        end else begin
            // Auto launch is offered on the first edge after reset only.
            r_auto_pending <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start || (r_auto_pending && r_state == ST_IDLE)) begin
                        r_state       <= ST_SET_ID;
                        r_address     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_fail_code   <= FC_NONE;
                        r_retry_count <= '0;
                    end
                end
                ST_SET_ID: r_state <= ST_SMP_ID;
                ST_SMP_ID: begin
                    if (w_smp_last) begin
                        r_captured_id <= w_smp_word;
                        r_address     <= 1'b1;
                        r_state       <= ST_SET_TS;
                    end
                end
                ST_SET_TS: r_state <= ST_SMP_TS;
                ST_SMP_TS: begin
                    if (w_smp_last) begin
                        r_captured_ts <= w_smp_word;
                        r_state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_address <= 1'b0;
                    if (w_fail == FC_NONE) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else if (r_retry_count < RETRY_CNT_W'(MAX_RETRIES)) begin
                        r_retry_count <= r_retry_count + 1'b1;
                        r_state       <= ST_SET_ID;
                    end else begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= w_fail;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sysid_address = r_address;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail_code     = r_fail_code;
    assign captured_id   = r_captured_id;
    assign captured_ts   = r_captured_ts;
    assign retry_count   = r_retry_count;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_ctrl
// Two instances: A (SAMPLES=4, MAX_RETRIES=3, AUTO_START=1) and
// B (SAMPLES=1, MAX_RETRIES=0, AUTO_START=0). Each has a stub sysid slave
// whose data can be XOR-corrupted on chosen sample cycles. Expected verdicts
// come from a pass-by-pass model of the check rules.
// -----------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1365185748;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rstn    [2];
    logic        start_s [2];
    logic [31:0] id_val  [2];
    logic [31:0] ts_val  [2];
    logic [31:0] glitch  [2];
    logic        addr    [2];
    logic [31:0] rd      [2];
    logic        busy    [2];
    logic        done    [2];
    logic        pass    [2];
    logic [1:0]  fc      [2];
    logic [31:0] cid     [2];
    logic [31:0] cts     [2];
    logic [3:0]  rc      [2];

    int n_checks = 0;
    int n_errors = 0;

    assign rd[0] = (addr[0] ? ts_val[0] : id_val[0]) ^ glitch[0];
    assign rd[1] = (addr[1] ? ts_val[1] : id_val[1]) ^ glitch[1];

    sysid_check_ctrl #(
        .EXPECTED_ID (EXP_ID), .EXPECTED_TS (EXP_TS),
        .SAMPLES (4), .MAX_RETRIES (3), .AUTO_START (1'b1)
    ) u_dut_a (
        .clock (clock), .reset_n (rstn[0]), .start (start_s[0]),
        .sysid_address (addr[0]), .sysid_readdata (rd[0]),
        .busy (busy[0]), .done (done[0]), .pass (pass[0]), .fail_code (fc[0]),
        .captured_id (cid[0]), .captured_ts (cts[0]), .retry_count (rc[0])
    );

    sysid_check_ctrl #(
        .EXPECTED_ID (EXP_ID), .EXPECTED_TS (EXP_TS),
        .SAMPLES (1), .MAX_RETRIES (0), .AUTO_START (1'b0)
    ) u_dut_b (
        .clock (clock), .reset_n (rstn[1]), .start (start_s[1]),
        .sysid_address (addr[1]), .sysid_readdata (rd[1]),
        .busy (busy[1]), .done (done[1]), .pass (pass[1]), .fail_code (fc[1]),
        .captured_id (cid[1]), .captured_ts (cts[1]), .retry_count (rc[1])
    );

    function automatic int smp_of(input int inst);
        return (inst == 0) ? 4 : 1;
    endfunction

    function automatic int mr_of(input int inst);
        return (inst == 0) ? 3 : 0;
    endfunction

    typedef struct {
        bit          pass;
        logic [1:0]  fc;
        int          retries;
        logic [31:0] cap_id;
        logic [31:0] cap_ts;
        int          latency;
    } exp_t;

    // Pass-by-pass model. g_pass: -1 no corruption, -2 every pass, else the
    // pass index that sees g_mask XORed into sample g_smp of word g_word.
    function automatic exp_t model(input int samples, input int max_retries,
                                   input logic [31:0] idv, input logic [31:0] tsv,
                                   input int g_pass, input int g_word, input int g_smp,
                                   input logic [31:0] g_mask);
        exp_t        e;
        logic [31:0] first [2];
        logic [31:0] smp;
        logic [1:0]  f;
        bit          unstable;
        bit          hit;
        e = '{pass: 1'b0, fc: 2'd0, retries: 0, cap_id: '0, cap_ts: '0, latency: 0};
        for (int r = 0; r <= max_retries; r++) begin
            unstable = 1'b0;
            for (int wd = 0; wd < 2; wd++) begin
                for (int s = 0; s < samples; s++) begin
                    hit = (g_pass == -2 || g_pass == r) && wd == g_word && s == g_smp;
                    smp = ((wd == 0) ? idv : tsv) ^ (hit ? g_mask : 32'd0);
                    if (s == 0) first[wd] = smp;
                    else if (smp != first[wd]) unstable = 1'b1;
                end
            end
            e.cap_id  = first[0];
            e.cap_ts  = first[1];
            e.retries = r;
            e.latency = (r + 1) * (2 * (samples + 1) + 1);
            if (unstable)             f = 2'd3;
            else if (first[0] != EXP_ID) f = 2'd1;
            else if (first[1] != EXP_TS) f = 2'd2;
            else                      f = 2'd0;
            if (f == 2'd0) begin
                e.pass = 1'b1;
                e.fc   = 2'd0;
                return e;
            end
            if (r == max_retries) begin
                e.pass = 1'b0;
                e.fc   = f;
                return e;
            end
        end
        return e;
    endfunction

    // Launches one check (reset pulse for auto-start, or a start pulse), runs
    // it to completion with optional data corruption and an optional extra
    // start pulse on cycle extra_k after launch, then checks the verdict.
    task automatic run_check(input int inst, input bit by_start,
                             input logic [31:0] idv, input logic [31:0] tsv,
                             input int g_pass, input int g_word, input int g_smp,
                             input logic [31:0] g_mask, input int extra_k,
                             input string name);
        exp_t e;
        int   s, len, g_k, done_k, busy_drop, limit;
        s     = smp_of(inst);
        len   = 2 * (s + 1) + 1;
        g_k   = 2 + g_word * (s + 1) + g_smp;
        e     = model(s, mr_of(inst), idv, tsv, g_pass, g_word, g_smp, g_mask);
        limit = len * (mr_of(inst) + 1) + 4;
        id_val[inst] = idv;
        ts_val[inst] = tsv;
        glitch[inst] = '0;
        if (by_start) begin
            @(negedge clock);
            start_s[inst] = 1'b1;
            @(posedge clock);
            #1;
            start_s[inst] = 1'b0;
        end else begin
            @(negedge clock);
            rstn[inst] = 1'b0;
            @(negedge clock);
            rstn[inst] = 1'b1;
            @(posedge clock);
            #1;
        end
        n_checks++;
        if ({busy[inst], done[inst], pass[inst], fc[inst], rc[inst]} !== {1'b1, 1'b0, 1'b0, 2'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL %s launch: busy/done/pass/fc/rc=%b/%b/%b/%0d/%0d want 1/0/0/0/0",
                     name, busy[inst], done[inst], pass[inst], fc[inst], rc[inst]);
        end
        done_k    = -1;
        busy_drop = 0;
        for (int k = 1; k <= limit && done_k < 0; k++) begin
            glitch[inst]  = ((k % len) == g_k && (g_pass == -2 || (g_pass >= 0 && k / len == g_pass)))
                            ? g_mask : 32'd0;
            start_s[inst] = (k == extra_k);
            @(posedge clock);
            #1;
            if (done[inst] === 1'b1) done_k = k;
            else if (busy[inst] !== 1'b1) busy_drop++;
        end
        glitch[inst]  = '0;
        start_s[inst] = 1'b0;
        n_checks++;
        if (done_k != e.latency) begin
            n_errors++;
            $display("FAIL %s latency: got %0d want %0d (-1 = never)", name, done_k, e.latency);
        end
        n_checks++;
        if (busy_drop != 0) begin
            n_errors++;
            $display("FAIL %s busy_hold: busy low on %0d cycles before done, want 0", name, busy_drop);
        end
        n_checks++;
        if ({busy[inst], addr[inst]} !== 2'b00) begin
            n_errors++;
            $display("FAIL %s busy/addr at done: got %b%b want 00", name, busy[inst], addr[inst]);
        end
        n_checks++;
        if (pass[inst] !== e.pass || fc[inst] !== e.fc) begin
            n_errors++;
            $display("FAIL %s verdict: pass=%b fc=%0d want pass=%b fc=%0d",
                     name, pass[inst], fc[inst], e.pass, e.fc);
        end
        n_checks++;
        if (rc[inst] !== 4'(e.retries)) begin
            n_errors++;
            $display("FAIL %s retry_count: got %0d want %0d", name, rc[inst], e.retries);
        end
        n_checks++;
        if (cid[inst] !== e.cap_id || cts[inst] !== e.cap_ts) begin
            n_errors++;
            $display("FAIL %s captured: id=%h ts=%h want id=%h ts=%h",
                     name, cid[inst], cts[inst], e.cap_id, e.cap_ts);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if ({done[inst], busy[inst]} !== 2'b10) begin
            n_errors++;
            $display("FAIL %s done_hold: done/busy=%b%b want 10", name, done[inst], busy[inst]);
        end
    endtask

    task automatic test_reset();
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({addr[i], busy[i], done[i], pass[i], fc[i], cid[i], cts[i], rc[i]} !== '0) begin
                n_errors++;
                $display("FAIL reset inst%0d: addr/busy/done/pass=%b%b%b%b fc=%0d id=%h ts=%h rc=%0d want all 0",
                         i, addr[i], busy[i], done[i], pass[i], fc[i], cid[i], cts[i], rc[i]);
            end
        end
    endtask

    task automatic test_no_auto_and_mid_reset();
        int viol;
        rstn[1] = 1'b1;
        viol = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (busy[1] !== 1'b0 || done[1] !== 1'b0) viol++;
        end
        n_checks++;
        if (viol != 0) begin
            n_errors++;
            $display("FAIL no_auto: busy/done seen on %0d cycles, want 0", viol);
        end
        id_val[1] = EXP_ID;
        ts_val[1] = EXP_TS;
        @(negedge clock);
        start_s[1] = 1'b1;
        @(posedge clock);
        #1;
        start_s[1] = 1'b0;
        @(posedge clock);
        #2;
        rstn[1] = 1'b0;
        #1;
        n_checks++;
        if ({addr[1], busy[1], done[1], pass[1], fc[1], rc[1]} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: addr/busy/done/pass=%b%b%b%b fc=%0d rc=%0d want all 0",
                     addr[1], busy[1], done[1], pass[1], fc[1], rc[1]);
        end
        @(negedge clock);
        rstn[1] = 1'b1;
        viol = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (busy[1] !== 1'b0 || done[1] !== 1'b0) viol++;
        end
        n_checks++;
        if (viol != 0) begin
            n_errors++;
            $display("FAIL post_reset_idle: busy/done seen on %0d cycles, want 0", viol);
        end
    endtask

    task automatic test_boundaries_b();
        run_check(1, 1'b1, EXP_ID, EXP_TS, -1, 0, 0, 32'd0, -1, "b_clean");
        run_check(1, 1'b1, 32'h5, EXP_TS, -1, 0, 0, 32'd0, -1, "b_id_final");
        run_check(1, 1'b1, EXP_ID, EXP_TS, 0, 0, 0, 32'h80, -1, "b_single_sample");
        run_check(1, 1'b1, EXP_ID, 32'h1, -1, 0, 0, 32'd0, -1, "b_ts_final");
    endtask

    task automatic test_main_a();
        run_check(0, 1'b0, EXP_ID, EXP_TS, -1, 0, 0, 32'd0, -1, "clean_auto");
        run_check(0, 1'b1, 32'h1, EXP_TS, -1, 0, 0, 32'd0, -1, "id_mismatch");
        run_check(0, 1'b1, EXP_ID, EXP_TS, 0, 1, 2, 32'h1, -1, "ts_glitch");
        run_check(0, 1'b1, EXP_ID, 32'h1234, -2, 0, 1, 32'h10, -1, "unstable_prio");
    endtask

    task automatic test_back_to_back();
        run_check(0, 1'b1, EXP_ID, EXP_TS, -1, 0, 0, 32'd0, 8, "start_busy");
        run_check(0, 1'b1, EXP_ID, EXP_TS, -1, 0, 0, 32'd0, 11, "start_at_done");
        run_check(0, 1'b1, EXP_ID, EXP_TS, -1, 0, 0, 32'd0, -1, "restart");
    endtask

    task automatic test_random();
        logic [31:0] idv, tsv, mask;
        int          gp;
        for (int n = 0; n < 20; n++) begin
            idv  = ($urandom_range(0, 3) != 0) ? EXP_ID : $urandom();
            tsv  = ($urandom_range(0, 3) != 0) ? EXP_TS : $urandom();
            gp   = int'($urandom_range(0, 4));
            if (gp == 4) gp = -2;
            mask = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom() | 32'd1);
            run_check(0, 1'b1, idv, tsv, gp, int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), mask, -1, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            id_val[i]  = EXP_ID;
            ts_val[i]  = EXP_TS;
            glitch[i]  = '0;
        end
        test_reset();
        test_no_auto_and_mid_reset();
        test_boundaries_b();
        test_main_a();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
Boot-time sequencer for the system ID Avalon slave. It reads the ID word (address 0) and the timestamp word (address 1), and samples each word repeatedly for stability. It compares both against expected parameters, retries on failure and latches a pass/fail verdict plus the captured words. It sits between reset release and the CPU boot gate, and it owns the sysid slave's address line until the check completes.

Parameters:
EXPECTED_ID, 32'd0, required value at sysid address 0
EXPECTED_TS, 32'd1365185748, required value at sysid address 1
SAMPLES, 4, consecutive reads per word; range 1..15
MAX_RETRIES, 3, full-sequence retries before FAIL; range 0..15
AUTO_START, 1, if 1, launch one check on the first cycle after reset release

Ports:
clock  in  1  system clock
reset_n  in  1  reset, asynchronous assert, active-low
start  in  1  single-cycle pulse; launches a check
sysid_address  out  1  drives the sysid slave address
sysid_readdata  in  32  sysid slave readdata (combinational from address)
busy  out  1  high while a check is in progress
done  out  1  high from check completion until the next accepted start
pass  out  1  valid when done=1; 1 = both words matched and were stable
fail_code  out  2  0 none, 1 ID mismatch, 2 TS mismatch, 3 unstable read
captured_id  out  32  last sampled ID word
captured_ts  out  32  last sampled TS word
retry_count  out  4  retries consumed by the current or last check

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; sample counter 0.
- States: IDLE, SET_ID, SMP_ID, SET_TS, SMP_TS, CHECK, DONE.
- Launch conditions: AUTO_START=1 gives one launch on the first clock edge after reset release. A start pulse launches a check when the state is IDLE or DONE.
- start while busy is ignored and is not queued.
- On launch: busy=1, done=0, pass=0, fail_code=0, retry_count=0.
- SET_ID: sysid_address registered to 0. Single settle cycle.
- SMP_ID: samples sysid_readdata on each of SAMPLES consecutive cycles.
  - First sample loads captured_id.
  - Any later sample differing from captured_id sets a sticky unstable flag.
  - After SAMPLES cycles, go to SET_TS.
- SET_TS and SMP_TS: identical to SET_ID and SMP_ID, with sysid_address=1 and captured_ts.
- CHECK (1 cycle): evaluate failures in priority order unstable, then ID mismatch, then TS mismatch.
  - No failure: go to DONE with pass=1.
  - Failure with retry_count < MAX_RETRIES: increment retry_count, clear the unstable flag, go to SET_ID.
  - Failure otherwise: go to DONE with pass=0 and fail_code set to the highest-priority failure.
- DONE: busy=0, done=1. sysid_address returns to 0.
- Clean-pass latency from launch to done=1 is 2*(SAMPLES+1)+1 cycles. Each retry adds the same amount.
- MAX_RETRIES=0: the first failure is final.
- SAMPLES=1: the unstable flag can never set.
- reset_n asserted mid-check: immediate return to the reset state. No verdict is latched.
- start in the same cycle as the transition into DONE: ignored. start must arrive at least one cycle after done rises.
- The sample counter and retry counter are exactly wide enough for their parameter ranges and never wrap.

Decomposition:
- Package sysid_check_pkg holds:
  - state enum
  - fail_code constants FC_NONE, FC_ID, FC_TS, FC_UNSTABLE
  - widths for the sample and retry counters
- One sub-module, sysid_word_sampler. It holds the SAMPLES-deep counter, the capture register and the sticky unstable flag. It is instantiated once and shared across the ID and TS phases; an enable and a clear are driven from the FSM.

Test Plan:
- Stub slave returns 0 at addr0 and 1365185748 at addr1, AUTO_START=1, SAMPLES=4 -> done rises 11 cycles after reset release; pass=1, fail_code=0, retry_count=0, captured_ts=1365185748.
- Stub returns 32'h1 at addr0 on every read, MAX_RETRIES=3 -> 4 full passes; done with pass=0, fail_code=1, retry_count=3, captured_id=1.
- Stub toggles bit 0 of the addr1 data on the third sample of the first pass only -> one retry; final pass=1, retry_count=1.
- start pulsed during SMP_TS -> ignored; the check completes once; a second start pulsed 2 cycles after done launches a new check with done=0 the next cycle.
- reset_n dropped mid-SMP_ID, then released with AUTO_START=0 -> outputs 0; state stays IDLE until start; no done.
- Stub has a wrong TS and the ID is unstable at the same time -> fail_code=3 (unstable has priority).
